timer_counter: RTL

//  Memory-mapped programmable down-counter; the bus responder for CPU lw/sw accesses to the TC windows.
//  The bridge instantiates two copies: TC1 at 0x0000_7F00..7F0B and TC2 at 0x0000_7F10..7F1B.
//  The CPU side guarantees word-only, aligned accesses and no stores to COUNT; this block still ignores such stores.

---
 rtl/timer_counter_pkg.sv | 28 ++
 rtl/timer_counter.sv | 103 ++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter bus block: window bases, register
// offsets, CTRL field layout, mode encodings and FSM state encoding.
package timer_counter_pkg;

  localparam logic [31:0] TC1_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC2_BASE = 32'h0000_7F10;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with CTRL/PRESET/COUNT registers
// and an interrupt request raised when the count expires.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | waiting for CTRL.EN
//  ST_LOAD | COUNT <= PRESET
//  ST_CNT  | decrementing; leaves on EN=0 (to IDLE) or terminal count
//  ST_INT  | raise irq_flag; one-shot modes drop EN, auto mode reloads
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TC1_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  tc_ctrl_t    ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  tc_state_e   state;

  logic        sel;
  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_addr_lsb;

  assign sel             = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset          = addr[3:2];
  assign wr_ctrl         = we && sel && (offset == TC_CTRL);
  assign wr_preset       = we && sel && (offset == TC_PRESET);
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    dout = 32'd0;
    if (sel) begin
      case (offset)
        TC_CTRL:   dout = {28'd0, ctrl};
        TC_PRESET: dout = preset;
        TC_COUNT:  dout = count;
        TC_RSVD:   dout = 32'd0;
        default:   dout = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag && ctrl.im;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (wr_ctrl)   ctrl   <= din[3:0];
      if (wr_preset) preset <= din;

      // any config write acknowledges a held one-shot interrupt
      if (wr_ctrl || wr_preset)
        irq_flag <= 1'b0;
      else if (irq_flag && (ctrl.mode == MODE_AUTO))
        irq_flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (ctrl.en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'd0;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          irq_flag <= 1'b1;
          state    <= ST_IDLE;
          // a CTRL store landing on this edge takes precedence over auto-clear
          if ((ctrl.mode != MODE_AUTO) && !wr_ctrl) ctrl.en <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
